// File: rtl/rate_switch_scheduler_if.sv
// Handshake bundle between the rate-switch scheduler, its requesters and the
// capture buffer. The scheduler takes the slave view; requesters/buffer the master.
interface rate_switch_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int PTS_W   = 16
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*PTS_W-1:0] req_points;
    logic [NUM_REQ-1:0]       grant;
    logic [ID_W-1:0]          grant_id;
    logic [NUM_REQ-1:0]       done;
    logic                     err_len;
    logic                     err_timeout;
    logic                     busy;
    logic                     rs_request;
    logic [31:0]              rs_piont_num;
    logic                     rs_data_vaild;
    logic                     rs_data_tlast;

    modport master (
        output req, req_points, rs_data_vaild, rs_data_tlast,
        input  grant, grant_id, done, err_len, err_timeout, busy,
               rs_request, rs_piont_num
    );

    modport slave (
        input  req, req_points, rs_data_vaild, rs_data_tlast,
        output grant, grant_id, done, err_len, err_timeout, busy,
               rs_request, rs_piont_num
    );
endinterface

// File: rtl/rate_switch_scheduler.sv
// Round-robin sequencer sharing the capture buffer between NUM_REQ requesters;
// issues each capture, checks the returned frame length and enforces a Request-low gap.
module rate_switch_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int PTS_W          = 16,
    parameter int MAX_POINTS     = 2046,
    parameter int MIN_GAP        = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   rd_clk,
    input  logic                   rst_n,
    rate_switch_scheduler_if.slave bus
);
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LAST,
        S_FINISH,
        S_GAP
    } state_t;

    state_t             r_state, w_state_next;
    logic [NUM_REQ-1:0] r_grant, w_grant_next;
    logic [ID_W-1:0]    r_grant_id, w_grant_id_next;
    logic [ID_W-1:0]    r_rr_ptr, w_rr_ptr_next;
    logic [NUM_REQ-1:0] r_done, w_done_next;
    logic               r_err_len, w_err_len_next;
    logic               r_err_tmo, w_err_tmo_next;
    logic               r_rs_request, w_rs_request_next;
    logic [PTS_W-1:0]   r_pts, w_pts_next;
    logic [PTS_W:0]     r_beat_cnt, w_beat_cnt_next;
    logic [31:0]        r_tmo_cnt, w_tmo_cnt_next;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_next;
    logic               r_abort, w_abort_next;

    logic [ID_W-1:0]    w_cand_id [NUM_REQ];
    logic [NUM_REQ-1:0] w_cand_hit;
    logic [PTS_W-1:0]   w_pts_clamped [NUM_REQ];
    logic               w_sel_valid;
    logic [ID_W-1:0]    w_sel_id;
    logic               w_tmo_hit;
    logic               w_last_beat;
    logic [PTS_W:0]     w_beat_inc;

    // Candidate gi is the requester gi+1 places after the last one served.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [ID_W:0]    w_sum;
        logic [PTS_W-1:0] w_raw;
        assign w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(gi + 1);
        assign w_cand_id[gi] = (w_sum >= (ID_W+1)'(NUM_REQ))
                             ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ)) : ID_W'(w_sum);
        assign w_cand_hit[gi] = bus.req[w_cand_id[gi]];
        assign w_raw = bus.req_points[gi*PTS_W +: PTS_W];
        assign w_pts_clamped[gi] = (w_raw == '0) ? PTS_W'(1)
                                 : (w_raw > PTS_W'(MAX_POINTS)) ? PTS_W'(MAX_POINTS) : w_raw;
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_cand_hit[i]) begin
                w_sel_valid = 1'b1;
                w_sel_id    = w_cand_id[i];
            end
        end
    end

    assign w_tmo_hit   = (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign w_last_beat = bus.rs_data_vaild && bus.rs_data_tlast;
    assign w_beat_inc  = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + 1'b1;

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_grant_id_next   = r_grant_id;
        w_rr_ptr_next     = r_rr_ptr;
        w_done_next       = '0;
        w_err_len_next    = 1'b0;
        w_err_tmo_next    = 1'b0;
        w_rs_request_next = r_rs_request;
        w_pts_next        = r_pts;
        w_beat_cnt_next   = r_beat_cnt;
        w_tmo_cnt_next    = r_tmo_cnt;
        w_gap_cnt_next    = r_gap_cnt;
        w_abort_next      = r_abort;
        case (r_state)
            S_IDLE: begin
                if (w_sel_valid) begin
                    w_grant_next      = NUM_REQ'(1) << w_sel_id;
                    w_grant_id_next   = w_sel_id;
                    w_pts_next        = w_pts_clamped[w_sel_id];
                    w_rs_request_next = 1'b1;
                    w_beat_cnt_next   = '0;
                    w_tmo_cnt_next    = '0;
                    w_abort_next      = 1'b0;
                    w_state_next      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_tmo_cnt_next = r_tmo_cnt + 32'd1;
                if (bus.rs_data_vaild) begin
                    w_rs_request_next = 1'b0;
                    w_beat_cnt_next   = (PTS_W+1)'(1);
                end
                // A terminating beat beats a timeout landing on the same edge.
                if (w_last_beat) begin
                    w_state_next = S_FINISH;
                end else if (w_tmo_hit) begin
                    w_rs_request_next = 1'b0;
                    w_abort_next      = 1'b1;
                    w_state_next      = S_FINISH;
                end else if (bus.rs_data_vaild) begin
                    w_state_next = S_WAIT_LAST;
                end
            end
            S_WAIT_LAST: begin
                w_tmo_cnt_next = r_tmo_cnt + 32'd1;
                if (bus.rs_data_vaild) begin
                    w_beat_cnt_next = w_beat_inc;
                end
                if (w_last_beat) begin
                    w_state_next = S_FINISH;
                end else if (w_tmo_hit) begin
                    w_abort_next = 1'b1;
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_done_next    = r_grant;
                w_err_tmo_next = r_abort;
                w_err_len_next = !r_abort && (r_beat_cnt != {1'b0, r_pts});
                w_rr_ptr_next  = r_grant_id;
                w_grant_next   = '0;
                w_gap_cnt_next = '0;
                w_state_next   = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_W'(MIN_GAP - 1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_rr_ptr     <= ID_W'(NUM_REQ - 1);
            r_done       <= '0;
            r_err_len    <= 1'b0;
            r_err_tmo    <= 1'b0;
            r_rs_request <= 1'b0;
            r_pts        <= '0;
            r_beat_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_grant_id   <= w_grant_id_next;
            r_rr_ptr     <= w_rr_ptr_next;
            r_done       <= w_done_next;
            r_err_len    <= w_err_len_next;
            r_err_tmo    <= w_err_tmo_next;
            r_rs_request <= w_rs_request_next;
            r_pts        <= w_pts_next;
            r_beat_cnt   <= w_beat_cnt_next;
            r_tmo_cnt    <= w_tmo_cnt_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_abort      <= w_abort_next;
        end
    end

    assign bus.grant        = r_grant;
    assign bus.grant_id     = r_grant_id;
    assign bus.done         = r_done;
    assign bus.err_len      = r_err_len;
    assign bus.err_timeout  = r_err_tmo;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.rs_request   = r_rs_request;
    assign bus.rs_piont_num = 32'(r_pts);
endmodule
